// File: rtl/counter_game_scheduler.sv
// Round-robin scheduler that shares one multi-mode counter between two players:
// it arbitrates, loads the seed and mode, watches GAMEOVER/WHO, scores, then clears the counter.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no holder; arbitrate pending requests
// S_LOAD  | one cycle: drive cnt_init with the captured seed and mode
// S_RUN   | holder plays; leave on gameover, release or slice expiry
// S_CLEAR | hold cnt_reset for RST_CYCLES cycles after a finished game
module counter_game_scheduler #(
    parameter int SLICE      = 16,
    parameter int RST_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] mode0,
    input  logic [1:0] mode1,
    input  logic [3:0] seed0,
    input  logic [3:0] seed1,
    input  logic       gameover,
    input  logic [1:0] who,
    output logic [1:0] cnt_control,
    output logic       cnt_init,
    output logic [3:0] cnt_initial_value,
    output logic       cnt_reset,
    output logic [1:0] grant,
    output logic       busy,
    output logic       round_done,
    output logic       winner_id,
    output logic [1:0] result,
    output logic [3:0] score0,
    output logic [3:0] score1
);

    localparam int SW = (SLICE > 1) ? $clog2(SLICE) : 1;
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [SW-1:0] SLICE_LAST = SW'(SLICE - 1);
    localparam logic [RW-1:0] RST_LAST   = RW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_CLEAR} state_t;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          holder_q, holder_d;
    logic [SW-1:0] slice_q, slice_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;

    logic [1:0] cnt_control_d;
    logic       cnt_init_d;
    logic [3:0] cnt_initial_value_d;
    logic       cnt_reset_d;
    logic [1:0] grant_d;
    logic       busy_d;
    logic       round_done_d;
    logic       winner_id_d;
    logic [1:0] result_d;
    logic [3:0] score0_d;
    logic [3:0] score1_d;

    logic win;
    logic hit0;
    logic hit1;

    // who=01 credits the holder, who=10 credits the opponent
    assign hit0 = ((who == 2'b01) && !holder_q) || ((who == 2'b10) && holder_q);
    assign hit1 = ((who == 2'b01) && holder_q) || ((who == 2'b10) && !holder_q);

    always_comb begin
        state_d             = state_q;
        ptr_d               = ptr_q;
        holder_d            = holder_q;
        slice_d             = slice_q;
        rst_cnt_d           = rst_cnt_q;
        cnt_control_d       = cnt_control;
        cnt_init_d          = 1'b0;
        cnt_initial_value_d = cnt_initial_value;
        cnt_reset_d         = cnt_reset;
        grant_d             = grant;
        round_done_d        = 1'b0;
        winner_id_d         = winner_id;
        result_d            = result;
        score0_d            = score0;
        score1_d            = score1;

        win = ptr_q;
        if (req == 2'b01) begin
            win = 1'b0;
        end else if (req == 2'b10) begin
            win = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    state_d             = S_LOAD;
                    holder_d            = win;
                    grant_d             = win ? 2'b10 : 2'b01;
                    cnt_init_d          = 1'b1;
                    cnt_initial_value_d = win ? seed1 : seed0;
                    cnt_control_d       = win ? mode1 : mode0;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
                slice_d = SLICE_LAST;
            end
            S_RUN: begin
                if (gameover) begin
                    state_d      = S_CLEAR;
                    ptr_d        = ~holder_q;
                    grant_d      = 2'b00;
                    cnt_reset_d  = 1'b1;
                    rst_cnt_d    = RST_LAST;
                    round_done_d = 1'b1;
                    winner_id_d  = holder_q;
                    result_d     = who;
                    if (hit0 && (score0 != 4'd15)) score0_d = score0 + 4'd1;
                    if (hit1 && (score1 != 4'd15)) score1_d = score1 + 4'd1;
                end else if (!req[holder_q] || (slice_q == '0)) begin
                    state_d = S_IDLE;
                    ptr_d   = ~holder_q;
                    grant_d = 2'b00;
                end else begin
                    slice_d = slice_q - SW'(1);
                end
            end
            S_CLEAR: begin
                if (rst_cnt_q == '0) begin
                    state_d     = S_IDLE;
                    cnt_reset_d = 1'b0;
                end else begin
                    rst_cnt_d = rst_cnt_q - RW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= S_IDLE;
            ptr_q             <= 1'b0;
            holder_q          <= 1'b0;
            slice_q           <= '0;
            rst_cnt_q         <= '0;
            cnt_control       <= 2'b00;
            cnt_init          <= 1'b0;
            cnt_initial_value <= 4'd0;
            cnt_reset         <= 1'b0;
            grant             <= 2'b00;
            busy              <= 1'b0;
            round_done        <= 1'b0;
            winner_id         <= 1'b0;
            result            <= 2'b00;
            score0            <= 4'd0;
            score1            <= 4'd0;
        end else begin
            state_q           <= state_d;
            ptr_q             <= ptr_d;
            holder_q          <= holder_d;
            slice_q           <= slice_d;
            rst_cnt_q         <= rst_cnt_d;
            cnt_control       <= cnt_control_d;
            cnt_init          <= cnt_init_d;
            cnt_initial_value <= cnt_initial_value_d;
            cnt_reset         <= cnt_reset_d;
            grant             <= grant_d;
            busy              <= busy_d;
            round_done        <= round_done_d;
            winner_id         <= winner_id_d;
            result            <= result_d;
            score0            <= score0_d;
            score1            <= score1_d;
        end
    end

endmodule
